// File: rtl/robot_pkg.sv
// Line-follower shared definitions: steering states, servo timing constants and
// the sensor-to-state map.
package robot_pkg;

  localparam int unsigned CNT_W         = 21;
  localparam int unsigned PERIOD_CYCLES = 2_000_000;
  localparam int unsigned PULSE_FWD_L   = 200_000;
  localparam int unsigned PULSE_STOP    = 150_000;
  localparam int unsigned PULSE_REV_L   = 100_000;

  typedef enum logic [2:0] {
    FORWARD,
    GENTLE_LEFT,
    SHARP_LEFT,
    GENTLE_RIGHT,
    SHARP_RIGHT
  } state_t;

  // Sensors are {l,m,r}, 0 = black line; unlisted patterns keep driving straight.
  function automatic state_t steer(input logic [2:0] lmr);
    case (lmr)
      3'b001:  return GENTLE_LEFT;
      3'b011:  return SHARP_LEFT;
      3'b100:  return GENTLE_RIGHT;
      3'b110:  return SHARP_RIGHT;
      default: return FORWARD;
    endcase
  endfunction

endpackage

// File: rtl/robot_motor_pwm.sv
// Registered servo pulse: high on the cycle after the shared timebase is below
// the commanded width.
module motor_pwm
  import robot_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] count,
  input  logic [W-1:0] width,
  output logic         pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse <= 1'b0;
    else        pulse <= (count < width);
  end

endmodule

// File: rtl/robot.sv
// Line-following robot controller: 20 ms timebase, steering FSM and two servo
// PWM channels. Optional macro ROBOT_SENSOR_SYNC_EN adds two-flop sensor synchronizers.
//
// state        | meaning
// FORWARD      | both wheels forward
// GENTLE_LEFT  | left wheel stopped, right forward
// SHARP_LEFT   | left wheel reverse, right forward
// GENTLE_RIGHT | left forward, right wheel stopped
// SHARP_RIGHT  | left forward, right wheel reverse
module robot
  import robot_pkg::*;
#(
  parameter int unsigned PERIOD = PERIOD_CYCLES,
  parameter int unsigned FWD_L  = PULSE_FWD_L,
  parameter int unsigned STOP   = PULSE_STOP,
  parameter int unsigned REV_L  = PULSE_REV_L
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_l,
  input  logic sensor_m,
  input  logic sensor_r,
  output logic motor_l_pwm,
  output logic motor_r_pwm
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] W_FWD  = CNT_W'(FWD_L);
  localparam logic [CNT_W-1:0] W_STOP = CNT_W'(STOP);
  localparam logic [CNT_W-1:0] W_REV  = CNT_W'(REV_L);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] width_l, width_r;
  logic [2:0]       sensors;
  state_t           state, state_nxt;

`ifdef ROBOT_SENSOR_SYNC_EN
  logic [2:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 3'b111;
      sync_q2 <= 3'b111;
    end else begin
      sync_q1 <= {sensor_l, sensor_m, sensor_r};
      sync_q2 <= sync_q1;
    end
  end

  assign sensors = sync_q2;
`else
  assign sensors = {sensor_l, sensor_m, sensor_r};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              count <= '0;
    else if (count == LAST)  count <= '0;
    else                     count <= count + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FORWARD;
    else        state <= state_nxt;
  end

  // Steering is only re-evaluated at the period boundary so a pulse in flight never changes.
  always_comb begin
    state_nxt = state;
    width_l   = W_FWD;
    width_r   = W_REV;
    if (count == LAST) state_nxt = steer(sensors);
    case (state)
      GENTLE_LEFT:  width_l = W_STOP;
      SHARP_LEFT:   width_l = W_REV;
      GENTLE_RIGHT: width_r = W_STOP;
      SHARP_RIGHT:  width_r = W_FWD;
      default: begin
        width_l = W_FWD;
        width_r = W_REV;
      end
    endcase
  end

  motor_pwm #(.W(CNT_W)) u_pwm_l (
    .clk   (clk),
    .rst_n (reset),
    .count (count),
    .width (width_l),
    .pulse (motor_l_pwm)
  );

  motor_pwm #(.W(CNT_W)) u_pwm_r (
    .clk   (clk),
    .rst_n (reset),
    .count (count),
    .width (width_r),
    .pulse (motor_r_pwm)
  );

endmodule

// File: tb/tb_robot.sv
// Scoreboard bench for robot with a shortened timebase (period 200, widths 40/30/20).
module tb_robot;

  localparam int PER = 200;
  localparam int WF  = 40;
  localparam int WS  = 30;
  localparam int WR  = 20;

  typedef struct {
    int l;
    int r;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sensor_l = 1'b0, sensor_m = 1'b0, sensor_r = 1'b0;
  logic motor_l_pwm, motor_r_pwm;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t e;
  bit   in_pulse = 0, have_prev = 0;
  int   len_l = 0, len_r = 0, prev_start = 0;
  logic [2:0] vecs [8] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b010, 3'b101, 3'b111};

  robot #(.PERIOD(PER), .FWD_L(WF), .STOP(WS), .REV_L(WR)) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_l    (sensor_l),
    .sensor_m    (sensor_m),
    .sensor_r    (sensor_r),
    .motor_l_pwm (motor_l_pwm),
    .motor_r_pwm (motor_r_pwm)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Hand table: left fwd=40 stop=30 rev=20; right fwd=20 stop=30 rev=40.
  function automatic exp_t expect_for(input logic [2:0] v);
    exp_t x;
    x.l = WF;
    x.r = WR;
    case (v)
      3'b001: x.l = WS;
      3'b011: x.l = WR;
      3'b100: x.r = WS;
      3'b110: x.r = WF;
      default: ;
    endcase
    return x;
  endfunction

  // Monitor: measure each pulse pair, check alignment and period, compare against queue.
  always @(negedge clk) begin
    if (!reset) begin
      in_pulse  = 0;
      have_prev = 0;
    end else begin
      if (!in_pulse && (motor_l_pwm || motor_r_pwm)) begin
        in_pulse = 1;
        len_l = 0;
        len_r = 0;
        chk("start_align", int'({motor_l_pwm, motor_r_pwm}), 3);
        if (have_prev) chk("period", cyc - prev_start, PER);
        prev_start = cyc;
        have_prev  = 1;
      end
      if (in_pulse) begin
        if (motor_l_pwm || motor_r_pwm) begin
          len_l += int'(motor_l_pwm);
          len_r += int'(motor_r_pwm);
        end else begin
          in_pulse = 0;
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("width_l", len_l, e.l);
            chk("width_r", len_r, e.r);
          end
        end
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    fork
      begin
        @(posedge clk);
        #1;
        chk("first_edge_l", int'(motor_l_pwm), 1);
        chk("first_edge_r", int'(motor_r_pwm), 1);
      end
    join_none
  endtask

  // One period: glitch the sensors to the complement early, settle to v mid-period.
  task automatic run_period(input logic [2:0] v);
    repeat (10) @(posedge clk);
    #1 {sensor_l, sensor_m, sensor_r} = ~v;
    repeat (40) @(posedge clk);
    #1 {sensor_l, sensor_m, sensor_r} = v;
    sb.push_back(expect_for(v));
    repeat (PER - 50) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int highs;
    highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (motor_l_pwm || motor_r_pwm) highs++;
    end
    chk("reset_hold", highs, 0);

    sb.push_back(expect_for(3'b000));
    release_reset();
    foreach (vecs[i]) run_period(vecs[i]);

    // Next period is FORWARD; hit reset at count 30 while only the left pulse is high.
    repeat (31) @(posedge clk);
    #2;
    chk("pre_reset_l", int'(motor_l_pwm), 1);
    chk("pre_reset_r", int'(motor_r_pwm), 0);
    reset = 1'b0;
    #1;
    chk("reset_async_l", int'(motor_l_pwm), 0);
    chk("reset_async_r", int'(motor_r_pwm), 0);
    sb.delete();
    {sensor_l, sensor_m, sensor_r} = 3'b000;
    repeat (5) @(negedge clk);

    sb.push_back(expect_for(3'b000));
    release_reset();
    run_period(3'b000);
    run_period(3'b011);
    repeat (PER / 2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/robot.md
ROBOT -- requirements
Module: robot

Interface
REQ-001 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock, 100 MHz (10 ns period); all logic on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 sensor_l  input  1  left line sensor; 0 = black line, 1 = white floor.
REQ-005 sensor_m  input  1  middle line sensor; same encoding.
REQ-006 sensor_r  input  1  right line sensor; same encoding.
REQ-007 motor_l_pwm  output  1  left servo-motor pulse, one pulse per 20 ms period.
REQ-008 motor_r_pwm  output  1  right servo-motor pulse, one pulse per 20 ms period.

Function
REQ-009 Timebase SHALL count 0..1,999,999 (20 ms at 100 MHz), then wrap to 0; 21-bit unsigned counter.
REQ-010 Pulse widths SHALL be: forward-left 200,000 cycles (2.0 ms), stop 150,000 cycles (1.5 ms), reverse-left 100,000 cycles (1.0 ms); the right motor is mirrored (forward 100,000, reverse 200,000, stop 150,000).
REQ-011 The controller FSM SHALL have the states FORWARD, GENTLE_LEFT, SHARP_LEFT, GENTLE_RIGHT and SHARP_RIGHT.
REQ-012 Sensor map {l,m,r}: 000, 010, 101 and 111 go to FORWARD; 001 goes to GENTLE_LEFT; 011 goes to SHARP_LEFT; 100 goes to GENTLE_RIGHT; 110 goes to SHARP_RIGHT.
REQ-013 Motor commands (left/right) SHALL be:
- FORWARD = fwd/fwd
- GENTLE_LEFT = stop/fwd
- SHARP_LEFT = rev/fwd
- GENTLE_RIGHT = fwd/stop
- SHARP_RIGHT = fwd/rev
REQ-014 The FSM SHALL update only on the cycle the counter equals 1,999,999; sensor changes mid-period never alter the current pulse.
REQ-015 Each output SHALL be registered: out(t+1) = (count(t) < width(state(t))); the pulse is high for exactly width cycles, starting one cycle after count 0.
REQ-016 The period SHALL be exactly 2,000,000 cycles, the same for both motors; pulses start in the same cycle.
REQ-017 Sensor values equal on simultaneous change: the sampled 3-bit vector at the update cycle alone decides the next state; no priority or debounce beyond REQ-014.

Reset
REQ-018 While reset = 0: counter = 0, state = FORWARD, motor_l_pwm = motor_r_pwm = 0, asynchronously.
REQ-019 After release, the first rising edge SHALL begin a full FORWARD period; motor_l_pwm is high for 200,000 cycles and motor_r_pwm for 100,000 cycles.
REQ-020 Reset asserted mid-pulse SHALL force both outputs low immediately; no partial-period state is retained.

Configuration
REQ-021 Macro ROBOT_SENSOR_SYNC_EN: when defined, each sensor input SHALL pass through a two-flop synchronizer (reset value 1) before the FSM, adding 2 cycles of sensor latency.
REQ-022 When ROBOT_SENSOR_SYNC_EN is undefined, the raw sensors feed the FSM directly; the PWM timing is identical in both builds.

Structure
REQ-023 Package robot_pkg SHALL hold:
- the state enum
- PERIOD_CYCLES = 2,000,000
- PULSE_FWD_L = 200,000
- PULSE_STOP = 150,000
- PULSE_REV_L = 100,000
- the counter width of 21
REQ-024 Sub-module motor_pwm (count, width -> registered pulse, async active-low reset) SHALL be instantiated once per motor; the timebase and FSM reside in robot.

Verification
REQ-025 Hold reset = 0 for 40 ms with sensors 000 -> both outputs stay 0 throughout.
REQ-026 Release reset, sensors 000 -> left pulses 2.0 ms high and right 1.0 ms high, every 20.000 ms.
REQ-027 Sensors 001 from 70 ms -> from the next period boundary, left 1.5 ms and right 1.0 ms; 011 -> left 1.0 ms, right 1.0 ms.
REQ-028 Sensors 100 -> left 2.0 ms, right 1.5 ms; 110 -> left 2.0 ms, right 2.0 ms; 010, 101, 111 -> left 2.0 ms, right 1.0 ms.
REQ-029 Toggle sensors at count 50,000 of a period -> the current pulse widths are unchanged and the new widths appear in the following period only.
REQ-030 Assert reset at count 120,000 during a left pulse -> both outputs fall within the same cycle; after release, a full FORWARD period follows.
